mpmc10_resv_table: RTL
======================

Name: mpmc10_resv_table

Overview:
- Reservation address table for the mpmc10 memory controller.
- Records load-reserve (LR) addresses per channel and clears them on conflicting writes.
- Drives the resv_ch/resv_adr arrays consumed downstream by the store-conditional reservation-status-bit stage.
- Sits beside the controller state machine; acts on requests only in the IDLE state, matching the downstream sampling point.

Parameters:
- NAR, 2: number of reservation entries; must equal mpmc10_pkg::NAR.
- INV_CH, 4'hF: channel code marking an empty entry; never used as a requester channel.

Ports:
- clk  in  1  controller clock
- rst_n  in  1  asynchronous active-low reset
- state  in  4  controller state; table acts only when state==mpmc10_pkg::IDLE
- req  in  1  request valid this cycle
- we  in  1  request is a write (plain store or store-conditional)
- rsv  in  1  request is a load-reserve (ignored when we=1)
- wch  in  4  requesting channel, 0..14
- adr  in  32  request byte address; reservation granule is adr[31:5]
- resv_ch  out  4 x NAR  channel owning each entry, INV_CH when empty
- resv_adr  out  32 x NAR  reserved address, adr[4:0] forced 0
- resv_cnt  out  $clog2(NAR+1)  number of occupied entries
- full  out  1  all NAR entries occupied

Behaviour:
- Reset (rst_n low, async): every resv_ch=INV_CH, resv_adr=0, round-robin pointer rp=0, resv_cnt=0, full=0. Reset mid-operation discards all reservations immediately; no request is acted on while rst_n is low.
- Act condition: act = rst_n && state==IDLE && req. With act=0, all state holds.
- All outputs are registered; updates are visible the cycle after act. The downstream stage therefore sees pre-update contents when evaluating the same write.
- Load-reserve (act && rsv && !we), with g = adr[31:5]:
  - Same-channel entry exists (resv_ch[i]==wch): overwrite its address with {g,5'b0}. A channel holds at most one reservation.
  - Else, at least one empty entry: fill the lowest-index empty entry; resv_cnt+1.
  - Else (full): replace entry rp; rp <= (rp==NAR-1) ? 0 : rp+1. Count unchanged.
  - rp advances only on replacement.
- Write (act && we, cr don't-care):
  - Every occupied entry whose resv_adr[31:5]==adr[31:5] is cleared to INV_CH/0, regardless of channel, including the writer's own entry.
  - resv_cnt decreases by the number of entries cleared.
  - A write whose granule matches nothing leaves the table unchanged.
- wch==INV_CH on any request: ignored, no state change.
- Duplicate granule from different channels: allowed, one entry each. A single write clears all of them in the same cycle.
- full = (resv_cnt==NAR), registered together with resv_cnt.
- Invariants:
  - Empty entries always read resv_ch=INV_CH and resv_adr=0.
  - No two occupied entries share a channel.
  - resv_cnt equals the popcount of occupied entries.

Test Plan:
- Reset, then LR ch2 adr 0x0000_1234 -> next cycle resv_ch[0]=2, resv_adr[0]=0x0000_1220, resv_cnt=1; resv_ch[1]=INV_CH.
- LR ch2 0x1220, then LR ch2 0x8000 -> resv_adr[0]=0x8000, resv_cnt stays 1, entry 1 still empty.
- NAR=2: LR ch1 0x100, LR ch3 0x200, LR ch5 0x300 -> entry 0 replaced by ch5/0x300, rp=1, full=1; LR ch6 0x400 -> entry 1 = ch6/0x400, rp=0.
- LR ch1 0x100 and ch3 0x11F; write ch7 adr 0x104 -> both entries cleared, resv_cnt=0. Write to 0x200 instead -> no change.
- LR ch4 0x40 with state!=IDLE -> no change; assert rst_n low mid-sequence with two entries -> all entries INV_CH/0 asynchronously, resv_cnt=0, full=0.
- LR with wch=INV_CH -> table unchanged, resv_cnt unchanged.

Source files
------------

// File: rtl/mpmc10_resv_table.sv
// mpmc10_resv_table
//   Reservation address table for the mpmc10 memory controller. It records the
//   load-reserve addresses for each channel. A write to a reserved 32-byte
//   granule clears every entry that holds that granule. The table acts only
//   while the controller is in IDLE, which is where the downstream
//   store-conditional stage samples it.
//
// Ports
//   clk       controller clock
//   rst_n     asynchronous active-low reset
//   state     controller state; requests are acted on only when state == IDLE
//   req       request valid
//   we        request is a write (plain store or store-conditional)
//   rsv       request is a load-reserve (ignored when we = 1)
//   wch       requesting channel; INV_CH requests are ignored
//   adr       request byte address; the reservation granule is adr[31:5]
//   resv_ch   channel owning each entry, INV_CH when the entry is empty
//   resv_adr  reserved address with bits [4:0] forced to 0
//   resv_cnt  number of occupied entries
//   full      all NAR entries are occupied

module mpmc10_resv_table #(
    parameter int          NAR    = 2,
    parameter logic [3:0]  INV_CH = 4'hF,
    parameter logic [3:0]  IDLE   = 4'h0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    state,
    input  logic                          req,
    input  logic                          we,
    input  logic                          rsv,
    input  logic [3:0]                    wch,
    input  logic [31:0]                   adr,
    output logic [NAR-1:0][3:0]           resv_ch,
    output logic [NAR-1:0][31:0]          resv_adr,
    output logic [$clog2(NAR+1)-1:0]      resv_cnt,
    output logic                          full
);

    localparam int CW = $clog2(NAR + 1);
    localparam int RW = (NAR > 1) ? $clog2(NAR) : 1;

    logic [NAR-1:0][3:0]  ch_q,  ch_d;
    logic [NAR-1:0][31:0] adr_q, adr_d;
    logic [RW-1:0]        rp_q,  rp_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 full_q, full_d;

    logic                 act;
    logic [26:0]          gran;
    logic                 hit_found, empty_found;
    logic [RW-1:0]        hit_idx, empty_idx;
    logic                 unused_adr_lo;

    assign unused_adr_lo = ^adr[4:0];
    assign gran = adr[31:5];
    // Reset gating is handled by the flops; an INV_CH requester never acts.
    assign act  = (state == IDLE) && req && (wch != INV_CH);

    always_comb begin
        ch_d        = ch_q;
        adr_d       = adr_q;
        rp_d        = rp_q;
        hit_found   = 1'b0;
        hit_idx     = '0;
        empty_found = 1'b0;
        empty_idx   = '0;

        for (int i = 0; i < NAR; i++) begin
            if (!hit_found && ch_q[i] == wch) begin
                hit_found = 1'b1;
                hit_idx   = RW'(i);
            end
            if (!empty_found && ch_q[i] == INV_CH) begin
                empty_found = 1'b1;
                empty_idx   = RW'(i);
            end
        end

        if (act && we) begin
            // Clear every matching occupied entry, the writer's own included.
            for (int i = 0; i < NAR; i++) begin
                if (ch_q[i] != INV_CH && adr_q[i][31:5] == gran) begin
                    ch_d[i]  = INV_CH;
                    adr_d[i] = '0;
                end
            end
        end else if (act && rsv) begin
            if (hit_found) begin
                adr_d[hit_idx] = {gran, 5'b0};
            end else if (empty_found) begin
                ch_d[empty_idx]  = wch;
                adr_d[empty_idx] = {gran, 5'b0};
            end else begin
                // Table full: round-robin replacement; rp moves only here.
                ch_d[rp_q]  = wch;
                adr_d[rp_q] = {gran, 5'b0};
                rp_d        = (rp_q == RW'(NAR - 1)) ? '0 : rp_q + RW'(1);
            end
        end

        // Count is recomputed from the next-state contents so it always
        // equals the number of occupied entries.
        cnt_d = '0;
        for (int i = 0; i < NAR; i++) begin
            if (ch_d[i] != INV_CH) begin
                cnt_d = cnt_d + CW'(1);
            end
        end
        full_d = (cnt_d == CW'(NAR));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q   <= {NAR{INV_CH}};
            adr_q  <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            ch_q   <= ch_d;
            adr_q  <= adr_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign resv_ch  = ch_q;
    assign resv_adr = adr_q;
    assign resv_cnt = cnt_q;
    assign full     = full_q;

endmodule
